// File: rtl/bennett_pkg.sv
// Shared types for the Bennett issue stage: FSM states, default widths and
// the packed instruction word carried through the FIFO.
package bennett_pkg;

  localparam int DW  = 8;
  localparam int OPW = 4;

  // Position within one Bennett cycle
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // nothing in flight (bubble cycle)
    S_HOLD = 2'd1,  // instruction held on the ALU rails, waiting for the ramp peak
    S_DONE = 2'd2   // result captured, waiting for the cycle boundary
  } state_t;

  typedef struct packed {
    logic [OPW-1:0] opcode;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
  } inst_t;

endpackage

// File: rtl/bennett_inst_fifo.sv
// Synchronous instruction FIFO. Head is read combinationally from the
// storage array; storage itself is not reset, only the pointers and count.
module bennett_inst_fifo
  import bennett_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  inst_t                      push_data,
  input  logic                       pop,
  output inst_t                      head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  inst_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  // Guard against writing when full or reading when empty
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage write; contents are don't-care once the count says empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of two)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bennett_issue_stage.sv
// Issue stage in front of the adiabatic ALU. Issues one buffered instruction
// per Bennett cycle on inst_flag, holds it stable through the ramp, captures
// the ALU result on fclk into a one-entry valid/ready buffer and records
// sticky overrun / sequencing errors.
module bennett_issue_stage
  import bennett_pkg::*;
#(
  parameter int DW    = bennett_pkg::DW,
  parameter int OPW   = bennett_pkg::OPW,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_opcode,
  input  logic [DW-1:0]  in_a,
  input  logic [DW-1:0]  in_b,
  input  logic           inst_flag,
  input  logic           fclk,
  output logic           alu_valid,
  output logic [OPW-1:0] alu_opcode,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  input  logic [DW-1:0]  alu_result,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_data,
  output logic           overrun,
  output logic           seq_err
);

  localparam int CW = $clog2(DEPTH+1);

  state_t         state;
  inst_t          push_data;
  inst_t          head;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic           capture;
  logic           room;
  logic           seq_viol;

  assign push_data = '{opcode: in_opcode, a: in_a, b: in_b};
  assign in_ready  = (count < CW'(DEPTH));
  assign push      = in_valid && !full;

  // Cycle boundary pops whenever something is queued; no same-cycle bypass
  assign pop = inst_flag && !empty;

  // A peak only counts while an instruction is held and no boundary competes
  assign capture = fclk && !inst_flag && (state == S_HOLD);

  // Output buffer can take a new result if empty or being drained this cycle
  assign room = !out_valid || out_ready;

  // Boundary+peak together, boundary without a peak, or a second peak
  assign seq_viol = (inst_flag && (fclk || (state == S_HOLD))) ||
                    (fclk && !inst_flag && (state == S_DONE));

  bennett_inst_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // Sequencing FSM and held ALU rails; rails move only when a real instruction issues
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      alu_valid  <= 1'b0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else if (inst_flag) begin
      if (!empty) begin
        state      <= S_HOLD;
        alu_valid  <= 1'b1;
        alu_opcode <= head.opcode;
        alu_a      <= head.a;
        alu_b      <= head.b;
      end else begin
        state      <= S_IDLE;
        alu_valid  <= 1'b0;
      end
    end else if (capture) begin
      state <= S_DONE;
    end
  end

  // One-entry result buffer with valid/ready drain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (capture && room) begin
      out_valid <= 1'b1;
      out_data  <= alu_result;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      if (capture && !room) overrun <= 1'b1;
      if (seq_viol)         seq_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bennett_issue_stage.sv
// Bench for bennett_issue_stage: directed scenarios with literal expectations
// followed by randomized traffic compared every cycle against a queue-based
// model of the issue/capture rules.
module tb_bennett_issue_stage;

  localparam int DW    = 8;
  localparam int OPW   = 4;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_opcode;
  logic [DW-1:0]  in_a;
  logic [DW-1:0]  in_b;
  logic           inst_flag;
  logic           fclk;
  logic           alu_valid;
  logic [OPW-1:0] alu_opcode;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [DW-1:0]  alu_result;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic           overrun;
  logic           seq_err;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  bit alu_auto = 1'b0;

  always #5 clk = ~clk;

  bennett_issue_stage #(.DW(DW), .OPW(OPW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_a      (in_a),
    .in_b      (in_b),
    .inst_flag (inst_flag),
    .fclk      (fclk),
    .alu_valid (alu_valid),
    .alu_opcode(alu_opcode),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_result(alu_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overrun   (overrun),
    .seq_err   (seq_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [OPW-1:0] op;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
  } ins_t;

  ins_t           mq[$];
  bit             m_valid = 0;
  logic [OPW-1:0] m_op = '0;
  logic [DW-1:0]  m_a = '0;
  logic [DW-1:0]  m_b = '0;
  int             m_phase = 0;   // 0 bubble, 1 awaiting peak, 2 peak already seen
  bit             m_oval = 0;
  logic [DW-1:0]  m_out = '0;
  bit             m_ovr = 0;
  bit             m_seq = 0;
  bit             m_take;
  bit             m_loaded;
  ins_t           m_h;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_valid = 0; m_op = '0; m_a = '0; m_b = '0; m_phase = 0;
      m_oval = 0; m_out = '0; m_ovr = 0; m_seq = 0;
    end else begin
      m_take   = in_valid && (mq.size() < DEPTH);
      m_loaded = 0;
      if (inst_flag) begin
        if (fclk || m_phase == 1) m_seq = 1;
        if (mq.size() != 0) begin
          m_h = mq.pop_front();
          m_op = m_h.op; m_a = m_h.a; m_b = m_h.b;
          m_valid = 1; m_phase = 1;
        end else begin
          m_valid = 0; m_phase = 0;
        end
      end else if (fclk && m_phase == 1) begin
        if (m_oval && !out_ready) m_ovr = 1;
        else begin m_out = alu_result; m_loaded = 1; end
        m_phase = 2;
      end else if (fclk && m_phase == 2) begin
        m_seq = 1;
      end
      if (m_loaded) m_oval = 1;
      else if (m_oval && out_ready) m_oval = 0;
      if (m_take) mq.push_back('{in_opcode, in_a, in_b});
    end
  end

  // Stand-in ALU for random traffic, driven from the model's held instruction
  always @(posedge clk) begin
    #1;
    if (alu_auto) alu_result = (m_a + m_b) ^ DW'(m_op);
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready",   in_ready,   (mq.size() < DEPTH));
      chk("alu_valid",  alu_valid,  m_valid);
      chk("alu_opcode", alu_opcode, m_op);
      chk("alu_a",      alu_a,      m_a);
      chk("alu_b",      alu_b,      m_b);
      chk("out_valid",  out_valid,  m_oval);
      chk("out_data",   out_data,   m_out);
      chk("overrun",    overrun,    m_ovr);
      chk("seq_err",    seq_err,    m_seq);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [OPW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    in_valid = 1; in_opcode = op; in_a = a; in_b = b;
    tick();
    in_valid = 0;
  endtask

  task automatic flag();
    inst_flag = 1;
    tick();
    inst_flag = 0;
  endtask

  task automatic peak(input logic [DW-1:0] res);
    fclk = 1; alu_result = res;
    tick();
    fclk = 0;
  endtask

  task automatic reset_pulse();
    reset_n = 0;
    tick();
    reset_n = 1;
    tick();
  endtask

  task automatic random_run(input int cycles, input bit inject);
    int ph;
    for (int c = 0; c < cycles; c++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      in_opcode = OPW'($urandom);
      in_a      = DW'($urandom);
      in_b      = DW'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      ph        = c % 6;
      inst_flag = (ph == 0);
      fclk      = (ph == 3);
      if (inject) begin
        if ($urandom_range(0, 19) == 0) inst_flag = ~inst_flag;
        if ($urandom_range(0, 19) == 0) fclk = ~fclk;
      end
      tick();
    end
    in_valid = 0; inst_flag = 0; fclk = 0;
  endtask

  initial begin
    reset_n = 0; in_valid = 0; in_opcode = '0; in_a = '0; in_b = '0;
    inst_flag = 0; fclk = 0; alu_result = '0; out_ready = 0;
    tick(); tick();
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_alu_valid", alu_valid, 0);
    chk("rst_alu_a",     alu_a,     0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_seq_err",   seq_err,   0);
    cmp_en = 1;
    reset_n = 1;
    tick();

    // Basic issue and capture
    push(4'd3, 8'h12, 8'h34);
    flag();
    chk("t1_alu_valid", alu_valid, 1);
    chk("t1_alu_op",    alu_opcode, 3);
    chk("t1_alu_a",     alu_a, 8'h12);
    chk("t1_alu_b",     alu_b, 8'h34);
    peak(8'h46);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_data",  out_data, 8'h46);
    out_ready = 1;
    tick();
    chk("t1_drain", out_valid, 0);

    // Fill past depth, then drain in order
    for (int i = 1; i <= 5; i++) begin
      push(OPW'(i), DW'(i), DW'(8'h10 + i));
      if (i >= 4) chk("t2_full_ready", in_ready, 0);
    end
    for (int i = 1; i <= 4; i++) begin
      flag();
      chk("t2_order_a", alu_a, i);
      peak(DW'(8'h40 + i));
      chk("t2_result", out_data, 8'h40 + i);
      chk("t2_out_valid", out_valid, 1);
    end

    // Empty FIFO: bubble cycle
    flag();
    chk("t3_bubble_valid", alu_valid, 0);
    chk("t3_held_a", alu_a, 8'h04);
    chk("t3_held_b", alu_b, 8'h14);
    peak(8'h99);
    chk("t3_no_capture", out_valid, 0);
    chk("t3_seq_err", seq_err, 0);

    // Backpressure overrun
    out_ready = 0;
    push(4'd1, 8'h01, 8'h01);
    push(4'd2, 8'h02, 8'h02);
    flag();
    peak(8'h11);
    chk("t4_first", out_data, 8'h11);
    flag();
    peak(8'h22);
    chk("t4_kept", out_data, 8'h11);
    chk("t4_overrun", overrun, 1);
    chk("t4_valid", out_valid, 1);
    out_ready = 1;
    tick();
    chk("t4_drain", out_valid, 0);

    // Double peak
    reset_pulse();
    chk("t5_ovr_clear", overrun, 0);
    push(4'd5, 8'h05, 8'h05);
    flag();
    peak(8'h55);
    peak(8'h66);
    chk("t5_seq_err", seq_err, 1);
    chk("t5_first_only", out_data, 8'h55);

    // Missing peak
    reset_pulse();
    push(4'd7, 8'h07, 8'h07);
    push(4'd8, 8'h08, 8'h08);
    flag();
    chk("t5b_first", alu_a, 8'h07);
    flag();
    chk("t5b_seq_err", seq_err, 1);
    chk("t5b_valid", alu_valid, 1);
    chk("t5b_next", alu_a, 8'h08);

    // Reset while holding with two queued
    out_ready = 0;
    for (int i = 1; i <= 4; i++) push(OPW'(i), DW'(8'h20 + i), DW'(i));
    flag();
    peak(8'h77);
    flag();
    chk("t6_pre_valid", out_valid, 1);
    chk("t6_pre_hold", alu_a, 8'h22);
    reset_n = 0;
    #1;
    chk("t6_alu_valid", alu_valid, 0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_overrun",   overrun, 0);
    chk("t6_seq_err",   seq_err, 0);
    chk("t6_in_ready",  in_ready, 1);
    tick();
    reset_n = 1;
    tick();

    // Randomized traffic: clean schedule, then with injected pulse faults
    alu_auto = 1;
    random_run(1500, 1'b0);
    reset_pulse();
    random_run(1500, 1'b1);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
